// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: operand width, multiplier FSM states and counter sizing.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 7;
  localparam int unsigned CALC_CNT_W = $clog2(CALC_WIDTH);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration: conditionally add the shifted multiplicand into the accumulator.
module mul_step
  import calc_pkg::*;
#(
  parameter int unsigned ProdW = 2 * CALC_WIDTH
) (
  input  logic [ProdW-1:0] acc_i,
  input  logic [ProdW-1:0] mcand_i,
  input  logic             mplier_lsb_i,
  output logic [ProdW-1:0] acc_o
);

  always_comb begin
    acc_o = mplier_lsb_i ? (acc_i + mcand_i) : acc_i;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier with start/done handshake, WIDTH RUN cycles per op.
// Build option MUL_OVF_EN adds a registered ovf output flagging products wider than WIDTH bits.
module seq_multiplier
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef MUL_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mul_state_t       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ProdW-1:0] acc_q, acc_d;
  logic [ProdW-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [ProdW-1:0] product_q, product_d;
  logic [ProdW-1:0] acc_step;
`ifdef MUL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  mul_step #(
    .ProdW (ProdW)
  ) u_mul_step (
    .acc_i        (acc_q),
    .mcand_i      (mcand_q),
    .mplier_lsb_i (mplier_q[0]),
    .acc_o        (acc_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
`ifdef MUL_OVF_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      MUL_IDLE, MUL_DONE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL_RUN;
        end else if (state_q == MUL_DONE) begin
          state_d = MUL_IDLE;
        end
      end
      MUL_RUN: begin
        // start is deliberately ignored here; operands stay as latched.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          product_d = acc_step;
`ifdef MUL_OVF_EN
          ovf_d     = |acc_step[ProdW-1:WIDTH];
`endif
          state_d   = MUL_DONE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MUL_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
`ifdef MUL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
`ifdef MUL_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q == MUL_RUN);
  assign done    = (state_q == MUL_DONE);
  assign product = product_q;
`ifdef MUL_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier against plain a*b arithmetic and the handshake timing.
module tb_seq_multiplier;

  localparam int unsigned W = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef MUL_OVF_EN
  logic           ovf;
`endif

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] last_product = '0;

  always #5 clk = ~clk;

  seq_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
`ifdef MUL_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands and start for one edge; with hold, start stays high afterwards.
  task automatic start_op(input int unsigned aa, input int unsigned bb, input bit hold,
                          input int unsigned na, input int unsigned nb);
    @(negedge clk);
    a = W'(aa);
    b = W'(bb);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    a = W'(na);
    b = W'(nb);
  endtask

  // Called just after the accepting edge; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input int unsigned aa, input int unsigned bb,
                           input int inject);
    int cycles = 0;
    int busy_cycles = 0;
    bit seen = 1'b0;
    bit held = 1'b1;
    int unsigned exp = aa * bb;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (inject > 0 && cycles == inject) begin
        start = 1'b1;
        a = W'(1);
        b = W'(1);
      end else if (inject > 0 && cycles == inject + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cycles++;
      if (product !== last_product) held = 1'b0;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(W + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_product_held"}, 32'(held), 32'd1);
    check({tag, "_product"}, 32'(product), exp);
`ifdef MUL_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), (exp >= (32'd1 << W)) ? 32'd1 : 32'd0);
`endif
    last_product = (2*W)'(exp);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_product_kept"}, 32'(product), 32'(last_product));
  endtask

  task automatic run_op(input string tag, input int unsigned aa, input int unsigned bb);
    start_op(aa, bb, 1'b0, $urandom_range(0, 127), $urandom_range(0, 127));
    wait_done(tag, aa, bb, 0);
    after_done(tag);
  endtask

  initial begin
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
`ifdef MUL_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 5, 3);

    // Abort a running operation with reset.
    start_op(127, 127, 1'b0, 127, 127);
    repeat (3) @(negedge clk);
    check("midrun_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_product", 32'(product), 32'd0);
`ifdef MUL_OVF_EN
    check("midrun_rst_ovf", 32'(ovf), 32'd0);
`endif
    last_product = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) rst_n = 1'b1;
      check("midrun_no_done", 32'(done), 32'd0);
    end

    run_op("post_reset", 5, 3);
    run_op("max", 127, 127);
    run_op("zero", 0, 100);
    run_op("pow2", 64, 2);
    run_op("one", 1, 127);

    // Start pulse during RUN with different operands must be ignored.
    start_op(9, 9, 1'b0, 3, 4);
    wait_done("ignore_busy", 9, 9, 2);
    after_done("ignore_busy");

    // Back-to-back: start held through DONE picks up the next operands immediately.
    start_op(7, 11, 1'b1, 12, 10);
    wait_done("b2b_first", 7, 11, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom_range(0, 127));
    b = W'($urandom_range(0, 127));
    wait_done("b2b_second", 12, 10, 0);
    after_done("b2b_second");

    for (int i = 0; i < 20; i++) begin
      int unsigned ra = $urandom_range(0, 127);
      int unsigned rb = $urandom_range(0, 127);
      run_op("random", ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
